// File: rtl/instr_exec_unit_pkg.sv
// Shared types for the execution stage: opcodes, operand widths and result record.
package instr_exec_unit_pkg;

    typedef enum logic [3:0] {
        OP_ZERO  = 4'd0,
        OP_PASSA = 4'd1,
        OP_PASSB = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MULT  = 4'd5,
        OP_DIV   = 4'd6,
        OP_MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] operand_r;
    typedef logic [4:0]         address_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } exec_state_t;

    localparam int DIV_ITER = 32;

    typedef struct packed {
        address_t addr;
        operand_r value;
        logic     div_zero;
        logic     illegal;
    } result_t;

    // Sign-extend a 32-bit operand to result width.
    function automatic operand_r sext(input operand_t v);
        return {{32{v[31]}}, v};
    endfunction

    // Unsigned magnitude; -2^31 maps to 2^31, which still fits in 32 unsigned bits.
    function automatic logic [31:0] mag(input operand_t v);
        logic [31:0] u;
        u = v;
        return u[31] ? (~u + 32'd1) : u;
    endfunction

endpackage

// File: rtl/instr_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// quotient/remainder/done reflect the step being performed this cycle, so the
// caller can register the final answer on the same edge as the last step.
module instr_divider
    import instr_exec_unit_pkg::*;
#(
    parameter int DIV_ITER = instr_exec_unit_pkg::DIV_ITER
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_W = $clog2(DIV_ITER);

    logic [31:0]      quo;
    logic [31:0]      rem;
    logic [31:0]      dvsr;
    logic [CNT_W-1:0] cnt;
    logic [32:0]      rem_sh;
    logic             ge;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh    = {rem, quo[31]};
        ge        = (rem_sh >= {1'b0, dvsr});
        quotient  = {quo[30:0], ge};
        remainder = ge ? 32'(rem_sh - {1'b0, dvsr}) : rem_sh[31:0];
        done      = busy && (cnt == '0);
    end

    // Load on start, then iterate until the terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo  <= '0;
            rem  <= '0;
            dvsr <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            quo  <= dividend;
            rem  <= '0;
            dvsr <= divisor;
            cnt  <= CNT_W'(DIV_ITER - 1);
            busy <= 1'b1;
        end else if (busy) begin
            quo <= quotient;
            rem <= remainder;
            if (cnt == '0)
                busy <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Multi-cycle execution stage: single-cycle ALU ops, iterative signed DIV/MOD.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// CALC  | divider iterating on operand magnitudes
// DONE  | result held on outputs until out_ready
module instr_exec_unit
    import instr_exec_unit_pkg::*;
#(
    parameter int DIV_ITER = instr_exec_unit_pkg::DIV_ITER
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  opcode_t  in_opc,
    input  operand_t in_op_a,
    input  operand_t in_op_b,
    input  address_t in_addr,
    output logic     out_valid,
    input  logic     out_ready,
    output address_t out_addr,
    output operand_r out_result,
    output logic     out_div_zero,
    output logic     out_illegal
);

    exec_state_t state;
    result_t     res_q;
    logic        q_neg;
    logic        r_neg;
    logic        is_mod;

    operand_r    imm_value;
    logic        imm_dz;
    logic        imm_ill;
    logic        is_div;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    operand_r    quo_ext;
    operand_r    rem_ext;
    operand_r    div_value;

    assign in_ready     = reset_n && (state == IDLE);
    assign out_addr     = res_q.addr;
    assign out_result   = res_q.value;
    assign out_div_zero = res_q.div_zero;
    assign out_illegal  = res_q.illegal;

    assign is_div    = (in_opc == OP_DIV) || (in_opc == OP_MOD);
    assign div_start = in_valid && in_ready && is_div && (in_op_b != '0);

    // Single-cycle results, plus flags for the div-by-zero and illegal bypasses.
    always_comb begin
        imm_value = '0;
        imm_dz    = 1'b0;
        imm_ill   = 1'b0;
        case (in_opc)
            OP_ZERO:        imm_value = '0;
            OP_PASSA:       imm_value = sext(in_op_a);
            OP_PASSB:       imm_value = sext(in_op_b);
            OP_ADD:         imm_value = sext(in_op_a) + sext(in_op_b);
            OP_SUB:         imm_value = sext(in_op_a) - sext(in_op_b);
            OP_MULT:        imm_value = sext(in_op_a) * sext(in_op_b);
            OP_DIV, OP_MOD: imm_dz    = (in_op_b == '0);
            default:        imm_ill   = 1'b1;
        endcase
    end

    // Sign fix on the divider's final step; quotient magnitude up to 2^31 stays positive.
    always_comb begin
        quo_ext   = {32'd0, div_quo};
        rem_ext   = {32'd0, div_rem};
        div_value = is_mod ? (r_neg ? -rem_ext : rem_ext)
                           : (q_neg ? -quo_ext : quo_ext);
    end

    instr_divider #(.DIV_ITER(DIV_ITER)) u_divider (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (mag(in_op_a)),
        .divisor   (mag(in_op_b)),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Control FSM with registered result record.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            res_q     <= '0;
            out_valid <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            is_mod    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        res_q.addr <= in_addr;
                        if (div_start) begin
                            q_neg  <= in_op_a[31] ^ in_op_b[31];
                            r_neg  <= in_op_a[31];
                            is_mod <= (in_opc == OP_MOD);
                            state  <= CALC;
                        end else begin
                            res_q.value    <= imm_value;
                            res_q.div_zero <= imm_dz;
                            res_q.illegal  <= imm_ill;
                            out_valid      <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                CALC: begin
                    if (div_done) begin
                        res_q.value    <= div_value;
                        res_q.div_zero <= 1'b0;
                        res_q.illegal  <= 1'b0;
                        out_valid      <= 1'b1;
                        state          <= DONE;
                    end else if (!div_busy) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Scoreboard bench for instr_exec_unit.
module tb_instr_exec_unit;
    import instr_exec_unit_pkg::*;

    logic     clk = 1'b0;
    logic     reset_n;
    logic     in_valid;
    logic     in_ready;
    opcode_t  in_opc;
    operand_t in_op_a;
    operand_t in_op_b;
    address_t in_addr;
    logic     out_valid;
    logic     out_ready;
    address_t out_addr;
    operand_r out_result;
    logic     out_div_zero;
    logic     out_illegal;

    int total = 0;
    int bad   = 0;
    result_t sb[$];

    instr_exec_unit #(.DIV_ITER(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opc       (in_opc),
        .in_op_a      (in_op_a),
        .in_op_b      (in_op_b),
        .in_addr      (in_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_result   (out_result),
        .out_div_zero (out_div_zero),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: value, flags and latency in edges counted from the accept edge.
    task automatic model(input opcode_t opc, input int a, input int b,
                         output longint ev, output bit dz, output bit ill, output int lat);
        longint la = a;
        longint lb = b;
        ev = 0; dz = 0; ill = 0; lat = 1;
        case (opc)
            OP_ZERO:  ev = 0;
            OP_PASSA: ev = la;
            OP_PASSB: ev = lb;
            OP_ADD:   ev = la + lb;
            OP_SUB:   ev = la - lb;
            OP_MULT:  ev = la * lb;
            OP_DIV:   if (b == 0) dz = 1; else begin ev = la / lb; lat = 33; end
            OP_MOD:   if (b == 0) dz = 1; else begin ev = la % lb; lat = 33; end
            default:  ill = 1;
        endcase
    endtask

    task automatic run_op(input opcode_t opc, input int a, input int b, input logic [4:0] addr,
                          input int hold, input string tag);
        result_t e;
        longint  ev;
        bit      dz;
        bit      ill;
        int      lat;
        int      edges;
        model(opc, a, b, ev, dz, ill, lat);
        e.addr = addr; e.value = ev; e.div_zero = dz; e.illegal = ill;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_opc    = opc;
        in_op_a   = a;
        in_op_b   = b;
        in_addr   = addr;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op_a  = $urandom;
        in_op_b  = $urandom;
        in_addr  = 5'($urandom);
        edges = 1;
        while (!out_valid && edges < lat + 8) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_lat"}, 64'(edges), 64'(lat));
        e = sb.pop_front();
        chk({tag, "_val"}, out_result, e.value);
        chk({tag, "_addr"}, 64'(out_addr), 64'(e.addr));
        chk({tag, "_dz"}, 64'(out_div_zero), 64'(e.div_zero));
        chk({tag, "_ill"}, 64'(out_illegal), 64'(e.illegal));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_opc   = OP_ADD;
            in_op_a  = $urandom;
            in_addr  = 5'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_val"}, out_result, e.value);
            chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_drain_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_drain_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        bit seen;
        opcode_t ops[5] = '{OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD};
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_opc    = OP_ZERO;
        in_op_a   = '0;
        in_op_b   = '0;
        in_addr   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_rdy", 64'(in_ready), 64'd0);
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_res", out_result, 64'd0);
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_flags", {62'd0, out_div_zero, out_illegal}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rdy", 64'(in_ready), 64'd1);

        run_op(OP_ADD, -5, 7, 5'd3, 0, "add");
        run_op(OP_MULT, 32'sh8000_0000, 32'sh8000_0000, 5'd4, 0, "mult_min");
        run_op(OP_DIV, -7, 2, 5'd5, 0, "div_neg");
        run_op(OP_MOD, -7, 2, 5'd6, 0, "mod_neg");
        run_op(OP_DIV, 32'sh8000_0000, -1, 5'd7, 0, "div_min");
        run_op(OP_MOD, 32'sh8000_0000, -1, 5'd8, 0, "mod_min");
        run_op(OP_MOD, 7, -2, 5'd9, 0, "mod_bneg");
        run_op(OP_DIV, 100, 7, 5'd10, 0, "div_pos");
        run_op(OP_DIV, 9, 0, 5'd11, 0, "div_zero");
        run_op(opcode_t'(4'hC), 1, 2, 5'd12, 0, "illegal");
        run_op(OP_PASSA, -1, 3, 5'd13, 0, "passa");
        run_op(OP_ZERO, 55, 66, 5'd14, 0, "zero");
        run_op(OP_ADD, 32'sh7fff_ffff, 32'sh7fff_ffff, 5'd15, 0, "add_max");
        run_op(OP_SUB, 3, 10, 5'd16, 10, "sub_hold");

        for (int i = 0; i < 8; i++) begin
            run_op(ops[$urandom_range(0, 4)], int'($urandom), int'($urandom_range(0, 1000)) - 500,
                   5'($urandom), 0, "rand");
        end

        // Abort a divide at iteration 15 with reset.
        @(negedge clk);
        in_valid = 1'b1;
        in_opc   = OP_DIV;
        in_op_a  = -7;
        in_op_b  = 2;
        in_addr  = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_rdy", 64'(in_ready), 64'd0);
        chk("abort_vld", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_rdy", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_out", 64'(seen), 64'd0);
        run_op(OP_PASSB, 0, 42, 5'd21, 0, "passb_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
